pll_drp_ctrl: RTL and testbench

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

---
 rtl/pll_drp_pkg.sv | 24 ++
 rtl/pll_drp_calc.sv | 24 ++
 rtl/pll_drp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// pll_drp_pkg: FSM states, DRP address map, clock-register field layout and error codes
package pll_drp_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT, ST_LOCK_WAIT
  } state_e;
  localparam logic [15:0] KEEP_MASK1 = 16'h1000;
  localparam logic [15:0] KEEP_MASK2 = 16'hFC00;
  localparam int CR1_PHASE_LSB = 13;
  localparam int CR1_HIGH_LSB = 6;
  localparam int CR1_LOW_LSB = 0;
  localparam int CR2_EDGE_BIT = 7;
  localparam int CR2_NOCNT_BIT = 6;
  localparam int CR2_DELAY_LSB = 0;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_BAD_REQ = 2'd1;
  localparam logic [1:0] ERR_LOCK_TO = 2'd2;
  localparam logic [1:0] ERR_DRDY_TO = 2'd3;
  // CLKOUT5 sits below CLKOUT0 in the DRP map; the others are contiguous pairs from 08
  function automatic logic [6:0] clkout_addr(input logic [2:0] ch, input logic idx);
    logic [6:0] base;
    base = (ch == 3'd5) ? 7'h06 : 7'h08 + {3'b000, ch, 1'b0};
    return base | {6'b0, idx};
  endfunction
endpackage

// File: rtl/pll_drp_calc.sv
// pll_drp_calc: divide/phase to ClkReg1/ClkReg2 field word plus the matching keep mask
module pll_drp_calc
  import pll_drp_pkg::*;
(
  input  logic [6:0]  div_i,
  input  logic [8:0]  phase_i,
  input  logic        idx_i,
  output logic [15:0] field_o,
  output logic [15:0] mask_o
);
  logic is1, is64;
  logic [5:0] high, low;
  logic [15:0] reg1, reg2;
  always_comb begin
    is1 = div_i == 7'd1;
    is64 = div_i == 7'd64;
    high = is1 ? 6'd1 : is64 ? 6'd0 : div_i[6:1];
    low = is1 ? 6'd1 : is64 ? 6'd0 : 6'(div_i - {1'b0, div_i[6:1]});
    reg1 = (16'(phase_i[2:0]) << CR1_PHASE_LSB) | (16'(high) << CR1_HIGH_LSB) | (16'(low) << CR1_LOW_LSB);
    reg2 = (16'(div_i[0] & ~is1) << CR2_EDGE_BIT) | (16'(is1) << CR2_NOCNT_BIT) | (16'(phase_i[8:3]) << CR2_DELAY_LSB);
    field_o = idx_i ? reg2 : reg1;
    mask_o = idx_i ? KEEP_MASK2 : KEEP_MASK1;
  end
endmodule

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: reprograms one PLL CLKOUT divider/phase via DRP read-modify-write, then waits for lock
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_ch_i,
  input  logic [6:0]  req_div_i,
  input  logic [8:0]  req_phase_i,
  output logic [6:0]  daddr_o,
  output logic        den_o,
  output logic        dwe_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic        pll_rst_o,
  input  logic        pll_locked_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        locked_o
);
  localparam int CNT_MAX = LOCK_TIMEOUT > DRDY_TIMEOUT ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 1);
  state_e state_q, state_d;
  logic idx_q, idx_d;
  logic [2:0] ch_q, ch_d;
  logic [6:0] div_q, div_d;
  logic [8:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic pll_rst_q, pll_rst_d, done_q, done_d, err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [1:0] sync_q;
  logic [15:0] field, mask;
  logic bad, drp_to, lock_to;
  pll_drp_calc u_calc (
    .div_i(div_q),
    .phase_i(phase_q),
    .idx_i(idx_q),
    .field_o(field),
    .mask_o(mask)
  );
  always_comb begin
    bad = 32'(req_ch_i) >= NUM_CH || req_div_i == 7'd0 || req_div_i > 7'd64;
    drp_to = cnt_q == CW'(DRDY_TIMEOUT - 1);
    lock_to = cnt_q == CW'(LOCK_TIMEOUT - 1);
    state_d = state_q;
    idx_d = idx_q;
    ch_d = ch_q;
    div_d = div_q;
    phase_d = phase_q;
    cnt_d = cnt_q + 1'b1;
    daddr_d = daddr_q;
    di_d = di_q;
    pll_rst_d = pll_rst_q;
    done_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          err_d = bad;
          code_d = bad ? ERR_BAD_REQ : ERR_NONE;
          if (!bad) begin
            ch_d = req_ch_i;
            div_d = req_div_i;
            phase_d = req_phase_i;
            idx_d = 1'b0;
            daddr_d = clkout_addr(req_ch_i, 1'b0);
            pll_rst_d = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        cnt_d = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drdy_i) begin
          di_d = (do_i & mask) | field;
          state_d = ST_WR;
        end else if (drp_to) begin
          err_d = 1'b1;
          code_d = ERR_DRDY_TO;
          pll_rst_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        cnt_d = '0;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drdy_i) begin
          cnt_d = '0;
          idx_d = 1'b1;
          daddr_d = clkout_addr(ch_q, 1'b1);
          pll_rst_d = !idx_q;
          state_d = idx_q ? ST_LOCK_WAIT : ST_RD;
        end else if (drp_to) begin
          err_d = 1'b1;
          code_d = ERR_DRDY_TO;
          pll_rst_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_LOCK_WAIT: begin
        if (sync_q[1]) begin
          done_d = 1'b1;
          state_d = ST_IDLE;
        end else if (lock_to) begin
          err_d = 1'b1;
          code_d = ERR_LOCK_TO;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q <= 1'b0;
      ch_q <= '0;
      div_q <= '0;
      phase_q <= '0;
      cnt_q <= '0;
      daddr_q <= '0;
      di_q <= '0;
      pll_rst_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ch_q <= ch_d;
      div_q <= div_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      daddr_q <= daddr_d;
      di_q <= di_d;
      pll_rst_q <= pll_rst_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
      sync_q <= {sync_q[0], pll_locked_i};
    end
  end
  assign req_ready_o = state_q == ST_IDLE;
  assign busy_o = state_q != ST_IDLE;
  assign den_o = state_q == ST_RD || state_q == ST_WR;
  assign dwe_o = state_q == ST_WR;
  assign daddr_o = daddr_q;
  assign di_o = di_q;
  assign pll_rst_o = pll_rst_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign err_code_o = code_q;
  assign locked_o = sync_q[1] && state_q == ST_IDLE;
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl: random and directed requests against a DRP slave model and a spec-level field calculator
module tb_pll_drp_ctrl;
  localparam int LOCK_DLY = 20;
  logic clk = 1'b0;
  logic rst_i, req_valid_i, req_ready_o, den_o, dwe_o, drdy_i, pll_rst_o, pll_locked_i;
  logic busy_o, done_o, err_o, locked_o;
  logic [2:0] req_ch_i;
  logic [6:0] req_div_i, daddr_o;
  logic [8:0] req_phase_i;
  logic [15:0] di_o, do_i;
  logic [1:0] err_code_o;
  int checks = 0, failures = 0;
  pll_drp_ctrl #(.NUM_CH(3), .LOCK_TIMEOUT(100), .DRDY_TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ch_i(req_ch_i), .req_div_i(req_div_i), .req_phase_i(req_phase_i),
    .daddr_o(daddr_o), .den_o(den_o), .dwe_o(dwe_o), .di_o(di_o), .do_i(do_i), .drdy_i(drdy_i),
    .pll_rst_o(pll_rst_o), .pll_locked_i(pll_locked_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .locked_o(locked_o)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [128];
  logic [15:0] do_m, pdi;
  logic [6:0] pa;
  logic drdy_m = 1'b0, drdy_x, hold, hold_wr, pend, pwe, den_prev, lock_en, lock;
  int lat, lcnt;
  int viol = 0, den_cnt = 0;
  logic [6:0] wa_q[$];
  logic [15:0] wd_q[$];
  assign drdy_i = drdy_m | drdy_x;
  assign do_i = do_m;
  assign pll_locked_i = lock;
  // DRP slave with random latency; also flags protocol breaches
  always @(posedge clk) begin
    drdy_m <= 1'b0;
    den_prev <= den_o;
    if (!rst_i)
      viol <= viol + int'(den_o && (den_prev || pend || !pll_rst_o)) + int'(done_o && err_o);
    if (rst_i) pend <= 1'b0;
    else if (den_o) begin
      pend <= 1'b1;
      pa <= daddr_o;
      pwe <= dwe_o;
      pdi <= di_o;
      lat <= int'($urandom_range(0, 3));
      den_cnt <= den_cnt + 1;
      if (dwe_o) begin
        wa_q.push_back(daddr_o);
        wd_q.push_back(di_o);
      end
    end else if (pend && !(hold || (hold_wr && pwe))) begin
      if (lat == 0) begin
        drdy_m <= 1'b1;
        pend <= 1'b0;
        do_m <= mem[pa];
        if (pwe) mem[pa] <= pdi;
      end else lat <= lat - 1;
    end
  end
  always @(posedge clk) begin
    if (pll_rst_o || !lock_en) begin
      lcnt <= 0;
      lock <= 1'b0;
    end else begin
      if (lcnt < LOCK_DLY) lcnt <= lcnt + 1;
      lock <= lcnt >= LOCK_DLY - 1;
    end
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [15:0] exp_word(input int div, input int ph, input bit idx, input logic [15:0] rd);
    int hi, lo, ed, nc;
    hi = div / 2;
    lo = div - hi;
    ed = div % 2;
    nc = 0;
    if (div == 1) begin hi = 1; lo = 1; ed = 0; nc = 1; end
    if (div == 64) begin hi = 0; lo = 0; end
    if (!idx) return (rd & 16'h1000) | 16'(((ph % 8) << 13) | (hi << 6) | lo);
    return (rd & 16'hFC00) | 16'((ed << 7) | (nc << 6) | (ph / 8));
  endfunction
  function automatic logic [32:0] outs();
    return {req_ready_o, den_o, dwe_o, daddr_o, di_o, pll_rst_o, busy_o, done_o, err_o, err_code_o, locked_o};
  endfunction
  task automatic send(input int ch, input int div, input int ph);
    req_ch_i = 3'(ch);
    req_div_i = 7'(div);
    req_phase_i = 9'(ph);
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask
  task automatic good_txn(input int ch, input int div, input int ph);
    logic [6:0] a0;
    logic [15:0] e0, e1;
    int wb;
    bit got;
    a0 = (ch == 5) ? 7'h06 : 7'(8 + 2 * ch);
    e0 = exp_word(div, ph, 1'b0, mem[a0]);
    e1 = exp_word(div, ph, 1'b1, mem[a0 | 7'd1]);
    wb = wa_q.size();
    check("ready", req_ready_o, 1);
    send(ch, div, ph);
    check("accept", {pll_rst_o, busy_o, req_ready_o, locked_o, err_o, err_code_o}, {5'b11000, 2'd0});
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = done_o | err_o;
    end
    check("done", {got, done_o, err_o}, 3'b110);
    check("locked", {locked_o, pll_rst_o, busy_o}, 3'b100);
    check("nwr", wa_q.size() - wb, 2);
    if (wa_q.size() >= wb + 2) begin
      check("wr0", {wa_q[wb], wd_q[wb]}, {a0, e0});
      check("wr1", {wa_q[wb+1], wd_q[wb+1]}, {a0 | 7'd1, e1});
    end
    @(negedge clk);
    check("done_pulse", {done_o, err_o}, 2'b00);
  endtask
  task automatic bad_txn(input int ch, input int div);
    int dc;
    dc = den_cnt;
    send(ch, div, 0);
    check("bad_err", {err_o, done_o, err_code_o, pll_rst_o, req_ready_o}, {2'b10, 2'd1, 2'b01});
    repeat (3) @(negedge clk);
    check("bad_quiet", {den_cnt - dc, pll_rst_o, err_o, err_code_o}, {32'd0, 2'b00, 2'd1});
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit got;
    rst_i = 1'b1; req_valid_i = 1'b0; req_ch_i = '0; req_div_i = '0; req_phase_i = '0;
    drdy_x = 1'b0; hold = 1'b0; hold_wr = 1'b0; lock_en = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[7'h0A] = 16'hFFFF;
    mem[7'h0B] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), {1'b1, 32'd0});
    rst_i = 1'b0;
    repeat (30) @(negedge clk);
    good_txn(1, 8, 0);
    good_txn(0, 1, 13);
    bad_txn(3, 8);
    bad_txn(0, 0);
    bad_txn(2, 100);
    good_txn(2, 64, 511);
    for (int i = 0; i < 8; i++)
      good_txn(int'($urandom_range(0, 2)), int'($urandom_range(1, 64)), int'($urandom_range(0, 511)));
    lock_en = 1'b0;
    send(1, 5, 7);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = !pll_rst_o;
    end
    check("lt_enter", {got, busy_o}, 2'b11);
    repeat (99) @(negedge clk);
    check("lt_pre", {err_o, busy_o}, 2'b01);
    @(negedge clk);
    check("lt_err", {err_o, done_o, err_code_o, req_ready_o, busy_o}, {2'b10, 2'd2, 2'b10});
    @(negedge clk);
    check("lt_after", {err_o, req_ready_o, err_code_o}, {2'b01, 2'd2});
    lock_en = 1'b1;
    repeat (30) @(negedge clk);
    hold = 1'b1;
    send(2, 9, 3);
    repeat (64) @(negedge clk);
    check("dt_pre", {err_o, pll_rst_o, busy_o}, 3'b011);
    @(negedge clk);
    check("dt_err", {err_o, err_code_o, pll_rst_o, busy_o, req_ready_o}, {1'b1, 2'd3, 3'b001});
    hold = 1'b0;
    repeat (8) @(negedge clk);
    check("dt_stray", {busy_o, den_o, err_o, done_o, err_code_o}, {4'b0000, 2'd3});
    repeat (30) @(negedge clk);
    hold_wr = 1'b1;
    send(0, 12, 100);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = den_o & dwe_o;
    end
    check("rw_wr", got, 1);
    repeat (2) @(negedge clk);
    check("rw_wait", {busy_o, den_o, pll_rst_o}, 3'b101);
    rst_i = 1'b1;
    @(negedge clk);
    check("rw_rst", outs(), {1'b1, 32'd0});
    rst_i = 1'b0;
    drdy_x = 1'b1;
    @(negedge clk);
    drdy_x = 1'b0;
    repeat (3) @(negedge clk);
    check("rw_stray", {busy_o, den_o, done_o, err_o, req_ready_o, pll_rst_o}, 6'b000010);
    hold_wr = 1'b0;
    repeat (30) @(negedge clk);
    good_txn(1, 33, 200);
    check("protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
